grf_wb_port: RTL and testbench

//  Write-side driver for the general register file: sole source of its WAddr/WData/RegWrite.

---
 rtl/grf_wb_port.sv | 115 +++++++++++
 tb/tb_grf_wb_port.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/grf_wb_port.sv
// grf_wb_port: GRF write-port arbiter merging the in-order WB stage with a FIFO of late mult/div results.
// Optional `GRF_WB_FWD_EN adds pend_fwd_data_o/pend_fwd_valid_o for forwarding pending writes.
module grf_wb_port #(
    parameter int DEPTH     = 4,
    parameter int MAX_DEFER = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_stall_o,
    input  logic        late_valid_i,
    output logic        late_ready_o,
    input  logic [4:0]  late_addr_i,
    input  logic [31:0] late_data_i,
    input  logic [4:0]  pend_query_i,
    output logic        pend_hit_o,
`ifdef GRF_WB_FWD_EN
    output logic [31:0] pend_fwd_data_o,
    output logic        pend_fwd_valid_o,
`endif
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        reg_write_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(MAX_DEFER + 1);

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q, idx;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] defer_q, defer_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          empty, full, wb_real, force_pop, pop, take_wb, push;
    logic          fifo_hit, out_hit;
    logic [31:0]   fifo_data;

    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DEPTH);
    assign wb_real      = wb_valid_i && wb_addr_i != '0;
    assign force_pop    = defer_q == DW'(MAX_DEFER) && !empty;
    assign pop          = force_pop || (!wb_real && !empty);
    assign take_wb      = wb_real && !force_pop;
    assign wb_stall_o   = wb_real && force_pop;
    assign late_ready_o = !full;
    // Address-0 late results complete the handshake but never enter the FIFO.
    assign push         = late_valid_i && !full && late_addr_i != '0;

    always_comb begin
        count_d     = count_q + CW'(push) - CW'(pop);
        defer_d     = (take_wb && !empty) ? ((defer_q == DW'(MAX_DEFER)) ? defer_q : defer_q + 1'b1) : '0;
        reg_write_d = pop || take_wb;
        waddr_d     = pop ? addr_q[rd_ptr_q] : take_wb ? wb_addr_i : waddr_q;
        wdata_d     = pop ? data_q[rd_ptr_q] : take_wb ? wb_data_i : wdata_q;
    end

    // Oldest to youngest, so the last match left standing is the youngest.
    always_comb begin
        fifo_hit  = 1'b0;
        fifo_data = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + AW'(k);
            if (CW'(k) < count_q && addr_q[idx] == pend_query_i) begin
                fifo_hit  = 1'b1;
                fifo_data = data_q[idx];
            end
        end
    end

    assign out_hit    = reg_write_q && waddr_q == pend_query_i;
    assign pend_hit_o = pend_query_i != '0 && (fifo_hit || out_hit);

`ifdef GRF_WB_FWD_EN
    assign pend_fwd_valid_o = pend_hit_o;
    assign pend_fwd_data_o  = out_hit ? wdata_q : fifo_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            defer_q     <= '0;
            reg_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= late_addr_i;
                data_q[wr_ptr_q] <= late_data_i;
            end
            wr_ptr_q    <= wr_ptr_q + AW'(push);
            rd_ptr_q    <= rd_ptr_q + AW'(pop);
            count_q     <= count_d;
            defer_q     <= defer_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign reg_write_o = reg_write_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
endmodule

// File: tb/tb_grf_wb_port.sv
// tb_grf_wb_port: directed checks of WB/late-result arbitration, FIFO order, starvation stall and pending lookup.
module tb_grf_wb_port;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wb_valid = 1'b0, late_valid = 1'b0;
    logic [4:0]  wb_addr = '0, late_addr = '0, pend_query = '0;
    logic [31:0] wb_data = '0, late_data = '0;
    logic        wb_stall, late_ready, pend_hit, reg_write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef GRF_WB_FWD_EN
    logic [31:0] fwd_data;
    logic        fwd_valid;
`endif
    int n_cmp = 0, n_bad = 0;

    grf_wb_port dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_stall_o(wb_stall),
        .late_valid_i(late_valid), .late_ready_o(late_ready), .late_addr_i(late_addr), .late_data_i(late_data),
        .pend_query_i(pend_query), .pend_hit_o(pend_hit),
`ifdef GRF_WB_FWD_EN
        .pend_fwd_data_o(fwd_data), .pend_fwd_valid_o(fwd_valid),
`endif
        .waddr_o(waddr), .wdata_o(wdata), .reg_write_o(reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One empty-FIFO push, then three pushes while WB keeps winning: leaves count=4, defer=MAX.
    task automatic fill(input logic [4:0] base);
        late_valid = 1'b1; late_addr = base; late_data = 32'h100 + 32'(base); wb_valid = 1'b0;
        tick();
        check("fill_rw0", 32'(reg_write), 0);
        for (int i = 1; i < 4; i++) begin
            late_addr = base + 5'(i); late_data = 32'h100 + 32'(base) + 32'(i);
            wb_valid = 1'b1; wb_addr = 5'(i); wb_data = 32'h10 * i;
            check("fill_stall", 32'(wb_stall), 0);
            tick();
            check("fill_waddr", 32'(waddr), 32'(i));
            check("fill_wdata", wdata, 32'h10 * i);
        end
        check("full_ready", 32'(late_ready), 0);
        late_valid = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_rw", 32'(reg_write), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", wdata, 0);
        check("rst_ready", 32'(late_ready), 1);
        check("rst_stall", 32'(wb_stall), 0);
        check("rst_hit", 32'(pend_hit), 0);
        rst_n = 1'b1;
        // 1: plain WB write, one-cycle latency
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        check("t1_stall", 32'(wb_stall), 0);
        tick();
        check("t1_rw", 32'(reg_write), 1);
        check("t1_waddr", 32'(waddr), 5);
        check("t1_wdata", wdata, 32'h1234);
        wb_valid = 1'b0;
        // 2: fill, no pass-through while full, drain in order
        fill(5'd8);
        late_valid = 1'b1; late_addr = 5'd20; late_data = 32'hDEAD;
        check("t2_full_ready", 32'(late_ready), 0);
        tick();
        late_valid = 1'b0;
        check("t2_ready_again", 32'(late_ready), 1);
        for (int a = 8; a < 12; a++) begin
            check("t2_rw", 32'(reg_write), 1);
            check("t2_waddr", 32'(waddr), 32'(a));
            check("t2_wdata", wdata, 32'h100 + 32'(a));
            tick();
        end
        check("t2_drained", 32'(reg_write), 0);
        // 3: starvation guard
        late_valid = 1'b1; late_addr = 5'd8; late_data = 32'h8A;
        tick();
        late_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        for (int i = 0; i < 3; i++) begin
            check("t3_nostall", 32'(wb_stall), 0);
            tick();
            check("t3_wb_waddr", 32'(waddr), 3);
        end
        check("t3_stall", 32'(wb_stall), 1);
        tick();
        check("t3_late_waddr", 32'(waddr), 8);
        check("t3_late_wdata", wdata, 32'h8A);
        check("t3_stall_off", 32'(wb_stall), 0);
        tick();
        check("t3_retry_waddr", 32'(waddr), 3);
        check("t3_retry_wdata", wdata, 32'h33);
        wb_valid = 1'b0;
        // 4: address-0 traffic is a no-op
        late_valid = 1'b1; late_addr = 5'd0; late_data = 32'hBAD0;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hBAD1;
        check("t4_ready", 32'(late_ready), 1);
        check("t4_stall", 32'(wb_stall), 0);
        tick();
        late_valid = 1'b0; wb_valid = 1'b0;
        check("t4_rw", 32'(reg_write), 0);
        tick();
        check("t4_nopush", 32'(reg_write), 0);
        // 5: pending lookup
        pend_query = 5'd12;
        late_valid = 1'b1; late_addr = 5'd12; late_data = 32'hC0C0;
        check("t5_hit_before", 32'(pend_hit), 0);
        tick();
        late_valid = 1'b0;
        check("t5_hit_fifo", 32'(pend_hit), 1);
`ifdef GRF_WB_FWD_EN
        check("t5_fwd_fifo", fwd_data, 32'hC0C0);
        check("t5_fwd_valid", 32'(fwd_valid), 1);
`endif
        pend_query = 5'd0; #1;
        check("t5_q0", 32'(pend_hit), 0);
        pend_query = 5'd12;
        tick();
        check("t5_rw", 32'(reg_write), 1);
        check("t5_hit_out", 32'(pend_hit), 1);
`ifdef GRF_WB_FWD_EN
        check("t5_fwd_out", fwd_data, 32'hC0C0);
`endif
        tick();
        check("t5_hit_after", 32'(pend_hit), 0);
        // 6: reset mid-drain
        fill(5'd13);
        tick();
        check("t6_pop", 32'(waddr), 13);
        rst_n = 1'b0; #1;
        check("t6_rw_async", 32'(reg_write), 0);
        check("t6_ready", 32'(late_ready), 1);
        check("t6_waddr", 32'(waddr), 0);
        tick();
        rst_n = 1'b1;
        pend_query = 5'd14;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_stale", 32'(reg_write), 0);
            check("t6_no_pend", 32'(pend_hit), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
